pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the ISA datapath.
- Adds the following on top of plain increment:
  - absolute jump load
  - PC-relative branch
  - call/return with a small hardware return-address stack (RAS)
  - stall
- Sits between the instruction-fetch address port and the decode/branch-resolution logic.
- Memory stays word-addressable, so the default step is 1.

Parameters:
- WIDTH, 32, PC and address width in bits.
- STEP, 1, increment applied on sequential advance (WIDTH bits, unsigned).
- RESET_VAL, 0, PC value after reset.
- RAS_DEPTH, 4, return-address stack entries (power of two, >= 2).
- OFF_W, 16, width of the signed branch offset.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  freeze all state for this cycle
- cnt_en  in  1  sequential advance, pc <= pc + STEP
- load_en  in  1  absolute jump, pc <= load_val
- load_val  in  WIDTH  jump/call target
- br_en  in  1  relative branch, pc <= pc + sign_ext(br_off)
- br_off  in  OFF_W  signed two's-complement branch offset
- call_en  in  1  pc <= load_val; push pc + STEP onto RAS
- ret_en  in  1  pc <= popped RAS entry
- pc  out  WIDTH  current program counter (registered)
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_empty  out  1  ras_count == 0 (combinational from count)
- ras_full  out  1  ras_count == RAS_DEPTH
- ras_ovf  out  1  one-cycle pulse: call issued while full
- ras_unf  out  1  one-cycle pulse: ret issued while empty

Behaviour:
- Reset: one clock, one active-high synchronous reset named rst (synchronous, active-high, fixed).
  - rst sampled high at a rising edge sets pc=RESET_VAL, ras_count=0, top pointer=0, ras_ovf=ras_unf=0.
  - rst overrides every other input, including stall.
  - Reset mid-call or mid-return discards the in-flight operation.
  - RAS storage contents are don't-care after reset.
- Priority, evaluated each non-reset edge: stall > ret_en > call_en > load_en > br_en > cnt_en > hold.
  - Only the highest-priority asserted request takes effect.
  - Lower requests in the same cycle are ignored; no queuing.
- Stall: pc, RAS pointer and count unchanged; ras_ovf/ras_unf driven 0.
- Latency: every operation updates pc at the edge it is sampled; new pc is visible the next cycle. No combinational path from inputs to pc.
- Arithmetic: all pc math is modulo 2^WIDTH.
  - pc + STEP at max value wraps to low values, e.g. 0xFFFFFFFF+1 = 0.
  - br_off is sign-extended to WIDTH; negative offsets wrap below 0 likewise.
- Call: pc <= load_val; RAS[top] <= pc + STEP; top pointer advances.
  - Not full: count increments.
  - Full: oldest entry is overwritten (circular), count stays RAS_DEPTH, ras_ovf pulses 1 for one cycle.
- Return:
  - Not empty: pc <= most recent pushed entry; top retreats; count decrements.
  - Empty: pc <= pc + STEP (fall-through), pointer/count unchanged, ras_unf pulses 1 for one cycle.
- Call and ret same cycle: ret wins; no push occurs.
- Pulses ras_ovf/ras_unf are registered and deassert the following cycle unless re-triggered.
- Hold (no request): all state unchanged.

Decomposition:
- Shared package pc_pkg:
  - op encoding enum PC_OP_HOLD, PC_OP_INC, PC_OP_BR, PC_OP_LOAD, PC_OP_CALL, PC_OP_RET
  - localparam default WIDTH/STEP/RESET_VAL
  - function for the priority decode from the six request bits
- One sub-module, pc_ras:
  - circular LIFO with push/pop, top pointer, count and ovf/unf flags
  - parametrised by WIDTH and RAS_DEPTH
  - same clk/rst
- pc_sequencer holds the pc register, next-pc mux and adders.

Test Plan:
- Reset and increment: rst high 1 cycle, then cnt_en=1 for 3 cycles -> pc 0,1,2,3; rst asserted with stall=1 -> pc=0.
- Load and branch: load_val=0x100, load_en=1 -> pc=0x100; then br_en, br_off=0xFFFC (-4) -> pc=0xFC; then br_off=0x0010 -> pc=0x10C.
- Call/return nest: pc=0x10; call to 0x200 -> pc=0x200, count=1; call to 0x300 -> pc=0x300, count=2; ret -> pc=0x201; ret -> pc=0x11, ras_empty=1.
- Overflow/underflow: 5 calls with RAS_DEPTH=4 -> ras_ovf pulses on 5th, count=4, four rets return the 5th..2nd return addresses; 5th ret -> ras_unf=1, pc advances by 1.
- Priority and stall: load_en+br_en+cnt_en together -> load wins; call_en+ret_en -> ret wins, no push; stall=1 with call_en -> pc, count unchanged, ras_ovf=0.
- Wrap: load_val=0xFFFFFFFF then cnt_en -> pc=0x0; pc=0x2 with br_off=-4 -> pc=0xFFFFFFFE.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
//   pc_op_e   : the one operation chosen for a cycle
//   PC_*_DEF  : default WIDTH / STEP / RESET_VAL
//   pc_decode : fixed-priority pick from the six request bits
package pc_pkg;

  typedef enum logic [2:0] {
    PC_OP_HOLD,
    PC_OP_INC,
    PC_OP_BR,
    PC_OP_LOAD,
    PC_OP_CALL,
    PC_OP_RET
  } pc_op_e;

  localparam int PC_WIDTH_DEF = 32;
  localparam int PC_STEP_DEF  = 1;
  localparam int PC_RESET_DEF = 0;

  // stall > ret > call > load > br > cnt > hold. A stall is a hold.
  function automatic pc_op_e pc_decode(input logic stall, input logic ret_en,
                                       input logic call_en, input logic load_en,
                                       input logic br_en, input logic cnt_en);
    if (stall)        return PC_OP_HOLD;
    else if (ret_en)  return PC_OP_RET;
    else if (call_en) return PC_OP_CALL;
    else if (load_en) return PC_OP_LOAD;
    else if (br_en)   return PC_OP_BR;
    else if (cnt_en)  return PC_OP_INC;
    else              return PC_OP_HOLD;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular LIFO of RAS_DEPTH entries.
// A push while full overwrites the oldest entry. A pop while empty
// changes nothing. Both cases raise a one-cycle registered flag.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   push, pop          : mutually exclusive requests (the caller guarantees this)
//   push_data          : address to push
//   top_data           : most recently pushed entry (combinational read)
//   count/empty/full   : occupancy
//   ovf/unf            : registered pulses for push-while-full / pop-while-empty
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top_data,
  output logic [$clog2(RAS_DEPTH):0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    top;   // next free slot; the depth is a power of two, so it wraps for free

  assign top_data = mem[top - PW'(1)];
  assign empty    = (count == '0);
  assign full     = (count == CW'(RAS_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      top   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      ovf <= push && full;
      unf <= pop && empty;
      if (push) begin
        top <= top + PW'(1);
        if (!full) count <= count + CW'(1);
      end else if (pop && !empty) begin
        top   <= top - PW'(1);
        count <= count - CW'(1);
      end
    end
  end

  // Storage is not reset. A push in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[top] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with increment, absolute load, relative branch,
// call/return through a hardware return-address stack, and stall.
// pc is registered. Each operation takes effect at the edge where it is
// sampled, and all arithmetic is modulo 2^WIDTH.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset (beats stall)
//   stall                    : freeze everything this cycle
//   cnt_en/load_en/br_en     : pc+STEP / load_val / pc+sext(br_off)
//   call_en/ret_en           : jump to load_val and push pc+STEP / pop into pc
//   load_val, br_off         : jump target, signed branch offset
//   pc                       : current program counter
//   ras_count/empty/full     : return-stack occupancy
//   ras_ovf/ras_unf          : one-cycle pulses for call-while-full / ret-while-empty
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                WIDTH     = PC_WIDTH_DEF,
  parameter logic [WIDTH-1:0]  STEP      = WIDTH'(PC_STEP_DEF),
  parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(PC_RESET_DEF),
  parameter int                RAS_DEPTH = 4,
  parameter int                OFF_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       cnt_en,
  input  logic                       load_en,
  input  logic [WIDTH-1:0]           load_val,
  input  logic                       br_en,
  input  logic [OFF_W-1:0]           br_off,
  input  logic                       call_en,
  input  logic                       ret_en,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_empty,
  output logic                       ras_full,
  output logic                       ras_ovf,
  output logic                       ras_unf
);

  pc_op_e           op;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] br_ext;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] pc_nxt;

  assign op     = pc_decode(stall, ret_en, call_en, load_en, br_en, cnt_en);
  assign pc_inc = pc + STEP;
  assign br_ext = WIDTH'($signed(br_off));

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (op == PC_OP_CALL),
    .pop       (op == PC_OP_RET),
    .push_data (pc_inc),
    .top_data  (ras_top),
    .count     (ras_count),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

  always_comb begin
    pc_nxt = pc;
    case (op)
      PC_OP_INC:  pc_nxt = pc_inc;
      PC_OP_BR:   pc_nxt = pc + br_ext;
      PC_OP_LOAD,
      PC_OP_CALL: pc_nxt = load_val;
      // A return with nothing on the stack falls through.
      PC_OP_RET:  pc_nxt = ras_empty ? pc_inc : ras_top;
      default:    pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_VAL;
    else     pc <= pc_nxt;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, cnt_en, load_en, br_en, call_en, ret_en;
  logic [31:0] load_val;
  logic [15:0] br_off;
  logic [31:0] pc;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .cnt_en(cnt_en), .load_en(load_en),
    .load_val(load_val), .br_en(br_en), .br_off(br_off), .call_en(call_en),
    .ret_en(ret_en), .pc(pc), .ras_count(ras_count), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  typedef struct {
    bit        rst, stall, cnt, ld;
    bit [31:0] lval;
    bit        br;
    bit [15:0] boff;
    bit        call, ret;
    bit [31:0] epc;
    int        ecnt;
    bit        eovf, eunf;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit r, input bit s, input bit c, input bit l,
                     input bit [31:0] lv, input bit b, input bit [15:0] bo,
                     input bit ca, input bit re, input bit [31:0] epc,
                     input int ecnt, input bit eo, input bit eu);
    vec_t v;
    v.rst = r; v.stall = s; v.cnt = c; v.ld = l; v.lval = lv; v.br = b;
    v.boff = bo; v.call = ca; v.ret = re; v.epc = epc; v.ecnt = ecnt;
    v.eovf = eo; v.eunf = eu;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; stall = v.stall; cnt_en = v.cnt; load_en = v.ld;
    load_val = v.lval; br_en = v.br; br_off = v.boff;
    call_en = v.call; ret_en = v.ret;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input vec_t v);
    chk("pc", idx, pc, v.epc);
    chk("ras_count", idx, 32'(ras_count), 32'(v.ecnt));
    chk("ras_empty", idx, 32'(ras_empty), 32'(v.ecnt == 0));
    chk("ras_full", idx, 32'(ras_full), 32'(v.ecnt == 4));
    chk("ras_ovf", idx, 32'(ras_ovf), 32'(v.eovf));
    chk("ras_unf", idx, 32'(ras_unf), 32'(v.eunf));
  endtask

  task automatic step(input int idx, input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check_all(idx, v);
  endtask

  localparam bit [15:0] M4 = 16'hFFFC;

  initial begin
    vec_t h;
    rst = 1'b0; stall = 1'b0; cnt_en = 1'b0; load_en = 1'b0; br_en = 1'b0;
    call_en = 1'b0; ret_en = 1'b0; load_val = '0; br_off = '0;

    //  rst s  c  ld lval          br boff    ca re  exp_pc        cnt ovf unf
    // reset and increment
    add(1, 0, 0, 0, 0,            0, 0,      0, 0, 32'h0,        0, 0, 0);
    add(0, 0, 1, 0, 0,            0, 0,      0, 0, 32'h1,        0, 0, 0);
    add(0, 0, 1, 0, 0,            0, 0,      0, 0, 32'h2,        0, 0, 0);
    add(0, 0, 1, 0, 0,            0, 0,      0, 0, 32'h3,        0, 0, 0);
    add(1, 1, 1, 0, 0,            0, 0,      0, 0, 32'h0,        0, 0, 0);
    // load and branch
    add(0, 0, 0, 1, 32'h100,      0, 0,      0, 0, 32'h100,      0, 0, 0);
    add(0, 0, 0, 0, 0,            1, M4,     0, 0, 32'hFC,       0, 0, 0);
    add(0, 0, 0, 0, 0,            1, 16'h10, 0, 0, 32'h10C,      0, 0, 0);
    // call/return nesting
    add(0, 0, 0, 1, 32'h10,       0, 0,      0, 0, 32'h10,       0, 0, 0);
    add(0, 0, 0, 0, 32'h200,      0, 0,      1, 0, 32'h200,      1, 0, 0);
    add(0, 0, 0, 0, 32'h300,      0, 0,      1, 0, 32'h300,      2, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,      0, 1, 32'h201,      1, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,      0, 1, 32'h11,       0, 0, 0);
    // overflow then underflow
    add(0, 0, 0, 0, 32'h1000,     0, 0,      1, 0, 32'h1000,     1, 0, 0);
    add(0, 0, 0, 0, 32'h2000,     0, 0,      1, 0, 32'h2000,     2, 0, 0);
    add(0, 0, 0, 0, 32'h3000,     0, 0,      1, 0, 32'h3000,     3, 0, 0);
    add(0, 0, 0, 0, 32'h4000,     0, 0,      1, 0, 32'h4000,     4, 0, 0);
    add(0, 0, 0, 0, 32'h5000,     0, 0,      1, 0, 32'h5000,     4, 1, 0);
    add(0, 0, 0, 0, 0,            0, 0,      0, 0, 32'h5000,     4, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,      0, 1, 32'h4001,     3, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,      0, 1, 32'h3001,     2, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,      0, 1, 32'h2001,     1, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,      0, 1, 32'h1001,     0, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,      0, 1, 32'h1002,     0, 0, 1);
    add(0, 0, 0, 0, 0,            0, 0,      0, 0, 32'h1002,     0, 0, 0);
    // priority
    add(0, 0, 1, 1, 32'h40,       1, 16'h4,  0, 0, 32'h40,       0, 0, 0);
    add(0, 0, 0, 0, 32'h80,       0, 0,      1, 1, 32'h41,       0, 0, 1);
    add(0, 0, 0, 0, 32'h500,      0, 0,      1, 0, 32'h500,      1, 0, 0);
    add(0, 0, 0, 0, 32'h900,      0, 0,      1, 1, 32'h42,       0, 0, 0);
    add(0, 0, 0, 0, 32'h600,      0, 0,      1, 0, 32'h600,      1, 0, 0);
    add(0, 0, 0, 0, 32'h700,      0, 0,      1, 0, 32'h700,      2, 0, 0);
    add(0, 0, 0, 0, 32'h800,      0, 0,      1, 0, 32'h800,      3, 0, 0);
    add(0, 0, 0, 0, 32'hA00,      0, 0,      1, 0, 32'hA00,      4, 0, 0);
    // stall freezes everything and suppresses the pulses
    add(0, 1, 1, 0, 32'hB00,      0, 0,      1, 0, 32'hA00,      4, 0, 0);
    add(0, 1, 0, 0, 0,            0, 0,      0, 1, 32'hA00,      4, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,      0, 1, 32'h801,      3, 0, 0);
    add(0, 0, 0, 0, 32'hC00,      0, 0,      1, 0, 32'hC00,      4, 0, 0);
    add(0, 0, 0, 0, 32'hD00,      0, 0,      1, 0, 32'hD00,      4, 1, 0);
    add(0, 1, 0, 0, 0,            0, 0,      0, 0, 32'hD00,      4, 0, 0);
    // reset discards a call in flight
    add(1, 0, 0, 0, 32'hE00,      0, 0,      1, 0, 32'h0,        0, 0, 0);
    // wrap-around
    add(0, 0, 0, 1, 32'hFFFFFFFF, 0, 0,      0, 0, 32'hFFFFFFFF, 0, 0, 0);
    add(0, 0, 1, 0, 0,            0, 0,      0, 0, 32'h0,        0, 0, 0);
    add(0, 0, 0, 1, 32'h2,        0, 0,      0, 0, 32'h2,        0, 0, 0);
    add(0, 0, 0, 0, 0,            1, M4,     0, 0, 32'hFFFFFFFE, 0, 0, 0);
    add(0, 0, 0, 0, 32'h10,       0, 0,      1, 0, 32'h10,       1, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,      0, 1, 32'hFFFFFFFF, 0, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,      0, 1, 32'h0,        0, 0, 1);
    add(0, 0, 0, 0, 0,            0, 0,      0, 0, 32'h0,        0, 0, 0);

    for (int i = 0; i < vq.size(); i++) step(i, vq[i]);

    // Hand sequence: back-to-back overflowing calls keep the pulse high,
    // a long stall holds the state, then it returns low.
    h = '{default: 0};
    h.rst = 1; h.epc = 0; step(100, h);
    h.rst = 0; h.call = 1;
    for (int i = 1; i <= 6; i++) begin
      h.lval = 32'h100 * i;
      h.epc  = h.lval;
      h.ecnt = (i > 4) ? 4 : i;
      h.eovf = (i > 4);
      step(100 + i, h);
    end
    h.stall = 1; h.cnt = 1; h.eovf = 0;
    for (int i = 0; i < 3; i++) step(110 + i, h);
    h.stall = 0; h.call = 0; h.cnt = 0; h.ret = 1;
    // The stack now holds the return addresses of calls 3..6: 0x201..0x501.
    for (int i = 0; i < 4; i++) begin
      h.epc  = 32'h100 * (5 - i) + 1;
      h.ecnt = 3 - i;
      step(120 + i, h);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
